// File: rtl/VX_gpu_pkg.sv
// Shared GPU types used by the execute-unit dispatch logic.
package VX_gpu_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } pe_disp_state_e;

endpackage

// File: rtl/vx_pe_credit_cnt.sv
// Per-PE in-flight credit counter: counts dispatched ops up and committed ops down.
module vx_pe_credit_cnt #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_next,
  output logic             o_full,
  output logic             o_underflow
);

  logic [CNT_W-1:0] r_count;
  logic             w_empty;
  logic             w_dec;

  assign w_empty     = (r_count == '0);
  assign o_full      = (r_count == CNT_W'(MAX_INFLIGHT));
  assign w_dec       = i_dec & ~w_empty;
  assign o_underflow = i_dec & w_empty;
  assign o_count     = r_count;

  // A retire and a dispatch in the same cycle cancel; the guards keep the counter from wrapping.
  always_comb begin
    o_count_next = r_count;
    if (i_inc && !w_dec && !o_full) begin
      o_count_next = r_count + CNT_W'(1);
    end else if (w_dec && !i_inc) begin
      o_count_next = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= o_count_next;
    end
  end

endmodule

// File: rtl/vx_pe_dispatch_ctrl.sv
// Dispatch scheduler for the execute-unit PE switch: credit-based issue gating,
// drain handshake for fences/warp control, and a sticky protocol error flag.
module vx_pe_dispatch_ctrl
  import VX_gpu_pkg::*;
#(
  parameter int PE_COUNT     = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int PE_SEL_BITS  = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 0,
  localparam int SEL_W       = (PE_SEL_BITS > 0) ? PE_SEL_BITS : 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req_valid,
  input  logic [SEL_W-1:0]    i_req_pe,
  output logic                o_req_ready,
  output logic                o_disp_valid,
  output logic [SEL_W-1:0]    o_disp_pe_sel,
  input  logic                i_disp_ready,
  input  logic [PE_COUNT-1:0] i_rsp_fire,
  input  logic                i_drain_req,
  output logic                o_drain_done,
  output logic [PE_COUNT-1:0] o_pe_busy,
  output logic                o_err
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  pe_disp_state_e      r_state;
  pe_disp_state_e      w_state_next;
  logic [CNT_W-1:0]    w_cnt      [PE_COUNT];
  logic [CNT_W-1:0]    w_cnt_next [PE_COUNT];
  logic [PE_COUNT-1:0] w_full;
  logic [PE_COUNT-1:0] w_underflow;
  logic [PE_COUNT-1:0] w_inc;
  logic                w_legal;
  logic                w_sel_full;
  logic                w_run;
  logic                w_can_issue;
  logic                w_issue_fire;
  logic                w_all_idle_next;
  logic                r_err;

  // Out-of-range PE indices never touch a counter; they are flagged as illegal instead.
  always_comb begin
    w_legal    = 1'b0;
    w_sel_full = 1'b0;
    for (int i = 0; i < PE_COUNT; i++) begin
      if (int'(i_req_pe) == i) begin
        w_legal    = 1'b1;
        w_sel_full = w_full[i];
      end
    end
  end

  assign w_can_issue   = w_run & w_legal & ~w_sel_full;
  assign o_disp_valid  = i_req_valid & w_can_issue & ~i_reset;
  assign o_req_ready   = ~i_reset & (w_can_issue ? i_disp_ready : (w_run & ~w_legal));
  assign w_issue_fire  = o_disp_valid & i_disp_ready;
  assign o_disp_pe_sel = i_req_pe;

  for (genvar g = 0; g < PE_COUNT; g++) begin : gen_pe
    assign w_inc[g]     = w_issue_fire & (int'(i_req_pe) == g);
    assign o_pe_busy[g] = (w_cnt[g] != '0);

    vx_pe_credit_cnt #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_W        (CNT_W)
    ) u_cnt (
      .i_clk        (i_clk),
      .i_rst        (i_reset),
      .i_inc        (w_inc[g]),
      .i_dec        (i_rsp_fire[g]),
      .o_count      (w_cnt[g]),
      .o_count_next (w_cnt_next[g]),
      .o_full       (w_full[g]),
      .o_underflow  (w_underflow[g])
    );
  end

  // Looking at next-cycle counts lets retires in the current cycle complete the drain.
  always_comb begin
    w_all_idle_next = 1'b1;
    for (int i = 0; i < PE_COUNT; i++) begin
      if (w_cnt_next[i] != '0) begin
        w_all_idle_next = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN: begin
        if (i_drain_req) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (!i_drain_req)         w_state_next = RUN;
        else if (w_all_idle_next) w_state_next = DONE;
      end
      DONE: begin
        if (!i_drain_req) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  always_comb begin
    w_run        = (r_state == RUN);
    o_drain_done = (r_state == DONE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if ((i_req_valid & w_run & ~w_legal) | (|w_underflow)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;

endmodule
